// File: rtl/pcileech_cfgspace_shadow_mf_if.sv
// Bus bundle for the multi-function config-space shadow: the cfg_ext event
// port from the PCIe core, the host load/monitor port and the error flag.
interface pcileech_cfgspace_shadow_mf_if;
   logic        cfg_ext_read_received;
   logic        cfg_ext_write_received;
   logic [9:0]  cfg_ext_register_number;
   logic [3:0]  cfg_ext_function_number;
   logic [31:0] cfg_ext_write_data;
   logic [3:0]  cfg_ext_write_byte_enable;
   logic [31:0] cfg_ext_read_data;
   logic        cfg_ext_read_data_valid;
   logic        host_req;
   logic        host_we;
   logic [1:0]  host_sel;
   logic [3:0]  host_fn;
   logic [9:0]  host_addr;
   logic [31:0] host_wdata;
   logic        host_ack;
   logic [31:0] host_rdata;
   logic        cfg_err;

   // shadow side
   modport slave (
      input  cfg_ext_read_received, cfg_ext_write_received,
             cfg_ext_register_number, cfg_ext_function_number,
             cfg_ext_write_data, cfg_ext_write_byte_enable,
             host_req, host_we, host_sel, host_fn, host_addr, host_wdata,
      output cfg_ext_read_data, cfg_ext_read_data_valid,
             host_ack, host_rdata, cfg_err
   );

   // PCIe core / host side
   modport master (
      output cfg_ext_read_received, cfg_ext_write_received,
             cfg_ext_register_number, cfg_ext_function_number,
             cfg_ext_write_data, cfg_ext_write_byte_enable,
             host_req, host_we, host_sel, host_fn, host_addr, host_wdata,
      input  cfg_ext_read_data, cfg_ext_read_data_valid,
             host_ack, host_rdata, cfg_err
   );
endinterface

// File: rtl/pcileech_cfgspace_shadow_mf.sv
// Multi-function, mask-driven PCIe configuration space shadow.
// Data, RW-mask and W1C-mask dwords live in three RAMs addressed by
// fn*DEPTH_DW + reg. cfg_ext events are parked in a one-entry slot and
// served by a serial IDLE->RD->MOD->RSP read-modify-write pipeline; the host
// port shares the same pipeline but yields to a pending cfg event.
module pcileech_cfgspace_shadow_mf #(
   parameter int    NUM_FUNCTIONS = 1,
   parameter int    DEPTH_DW      = 1024,
   parameter string INIT_FILE     = "config_space_init.hex",
   parameter string RW_MASK_FILE  = "",
   parameter string W1C_MASK_FILE = ""
) (
   input logic                         clk,
   input logic                         rst,
   pcileech_cfgspace_shadow_mf_if.slave bus
);

   localparam int MEM_N  = NUM_FUNCTIONS * DEPTH_DW;
   localparam int AW     = (MEM_N > 1) ? $clog2(MEM_N) : 1;
   localparam int MEM_SZ = 1 << AW;
   localparam logic [4:0]  FN_LIM  = 5'(NUM_FUNCTIONS);
   localparam logic [10:0] REG_LIM = 11'(DEPTH_DW);

   typedef enum logic [1:0] {IDLE, RD, MOD, RSP} state_t;

   // Flat RAM index: functions are stored back to back.
   function automatic logic [AW-1:0] mk_addr(input logic [3:0] fn, input logic [9:0] rg);
      return AW'(({10'd0, fn} * 14'(DEPTH_DW)) + {4'd0, rg});
   endfunction

   // Byte-enabled RW / W1C merge; a bit set in both masks behaves as W1C.
   function automatic logic [31:0] cfg_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [31:0] rw, input logic [31:0] w1c,
                                             input logic [3:0] be);
      logic [31:0] m;
      logic [31:0] r;
      m = (old & ~(rw | w1c)) | (wd & rw & ~w1c) | (old & w1c & ~wd);
      for (int b = 0; b < 4; b++)
         r[8*b +: 8] = be[b] ? m[8*b +: 8] : old[8*b +: 8];
      return r;
   endfunction

   logic [31:0] data_mem [0:MEM_SZ-1];
   logic [31:0] rw_mem   [0:MEM_SZ-1];
   logic [31:0] w1c_mem  [0:MEM_SZ-1];

   state_t      state;

   logic        slot_full;
   logic        slot_wr;
   logic [9:0]  slot_reg;
   logic [3:0]  slot_fn;
   logic [31:0] slot_data;
   logic [3:0]  slot_be;

   logic        op_cfg;
   logic        op_we;
   logic [1:0]  op_sel;
   logic [AW-1:0] op_addr;
   logic        op_oor;
   logic [31:0] op_wdata;
   logic [3:0]  op_be;

   logic [31:0] data_q;
   logic [31:0] rw_q;
   logic [31:0] w1c_q;

   logic [31:0] read_data;
   logic        read_valid;
   logic        ack;
   logic [31:0] rdata;
   logic        err;

   logic        ev_rd;
   logic        ev_wr;
   logic        ev_any;
   logic        take_slot;
   logic        take_host;
   logic        slot_oor;
   logic        host_oor;
   logic        err_set;
   logic [31:0] merged;
   logic [31:0] host_rval;
   logic        data_we;
   logic [31:0] data_wval;
   logic        rw_we;
   logic        w1c_we;

   assign ev_rd  = bus.cfg_ext_read_received;
   assign ev_wr  = bus.cfg_ext_write_received;
   assign ev_any = ev_rd | ev_wr;

   // The slot is drained from IDLE and straight out of RSP, so back-to-back
   // cfg events start a new operation every three cycles.
   assign take_slot = slot_full && (state == IDLE || state == RSP);
   assign take_host = (state == IDLE) && !slot_full && bus.host_req;

   assign slot_oor = ({1'b0, slot_fn} >= FN_LIM) || ({1'b0, slot_reg} >= REG_LIM);
   assign host_oor = ({1'b0, bus.host_fn} >= FN_LIM) || ({1'b0, bus.host_addr} >= REG_LIM);

   assign err_set = (ev_rd && ev_wr)
                  || (ev_any && slot_full && !take_slot)
                  || (take_slot && slot_oor);

   assign merged    = cfg_merge(data_q, op_wdata, rw_q, w1c_q, op_be);
   assign data_wval = op_cfg ? merged : op_wdata;
   assign data_we   = (state == MOD) && op_we && !op_oor && (op_cfg || op_sel == 2'd0);
   assign rw_we     = (state == MOD) && !op_cfg && op_we && !op_oor && (op_sel == 2'd1);
   assign w1c_we    = (state == MOD) && !op_cfg && op_we && !op_oor && (op_sel == 2'd2);

   assign host_rval = op_oor          ? 32'h0 :
                      (op_sel == 2'd0) ? data_q :
                      (op_sel == 2'd1) ? rw_q :
                      (op_sel == 2'd2) ? w1c_q : 32'h0;

   assign bus.cfg_ext_read_data       = read_data;
   assign bus.cfg_ext_read_data_valid = read_valid;
   assign bus.host_ack                = ack;
   assign bus.host_rdata              = rdata;
   assign bus.cfg_err                 = err;

   // Power-up contents: all RAMs start zeroed.
   initial begin
      for (int i = 0; i < MEM_SZ; i++) begin
         data_mem[i] = '0;
         rw_mem[i]   = '0;
         w1c_mem[i]  = '0;
      end
   end

   // Pending slot: latch any cfg event, read wins over a simultaneous write.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_full <= 1'b0;
      end else if (ev_any && (!slot_full || take_slot)) begin
         slot_full <= 1'b1;
         slot_wr   <= !ev_rd;
         slot_reg  <= bus.cfg_ext_register_number;
         slot_fn   <= bus.cfg_ext_function_number;
         slot_data <= bus.cfg_ext_write_data;
         slot_be   <= bus.cfg_ext_write_byte_enable;
      end else if (take_slot) begin
         slot_full <= 1'b0;
      end
   end

   // Sticky error flag for dropped cfg events and out-of-range cfg accesses.
   always_ff @(posedge clk) begin
      if (rst)          err <= 1'b0;
      else if (err_set) err <= 1'b1;
   end

   // Operation sequencer with registered result and pulse outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         read_valid <= 1'b0;
         ack        <= 1'b0;
         read_data  <= 32'h0;
         rdata      <= 32'h0;
      end else begin
         read_valid <= 1'b0;
         ack        <= 1'b0;
         case (state)
            IDLE, RSP: begin
               if (take_slot) begin
                  op_cfg   <= 1'b1;
                  op_we    <= slot_wr;
                  op_sel   <= 2'd0;
                  op_addr  <= mk_addr(slot_fn, slot_reg);
                  op_oor   <= slot_oor;
                  op_wdata <= slot_data;
                  op_be    <= slot_be;
                  state    <= RD;
               end else if (take_host) begin
                  op_cfg   <= 1'b0;
                  op_we    <= bus.host_we;
                  op_sel   <= bus.host_sel;
                  op_addr  <= mk_addr(bus.host_fn, bus.host_addr);
                  op_oor   <= host_oor;
                  op_wdata <= bus.host_wdata;
                  op_be    <= 4'hF;
                  state    <= RD;
               end else begin
                  state <= IDLE;
               end
            end
            RD: state <= MOD;
            MOD: begin
               state <= RSP;
               if (op_cfg) begin
                  if (!op_we) begin
                     read_valid <= 1'b1;
                     read_data  <= op_oor ? 32'h0 : data_q;
                  end
               end else begin
                  ack <= 1'b1;
                  if (!op_we) rdata <= host_rval;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Data RAM: registered read, write-back at the MOD->RSP edge.
   always_ff @(posedge clk) begin
      if (data_we && !rst) data_mem[op_addr] <= data_wval;
      data_q <= data_mem[op_addr];
   end

   // RW mask RAM.
   always_ff @(posedge clk) begin
      if (rw_we && !rst) rw_mem[op_addr] <= op_wdata;
      rw_q <= rw_mem[op_addr];
   end

   // W1C mask RAM.
   always_ff @(posedge clk) begin
      if (w1c_we && !rst) w1c_mem[op_addr] <= op_wdata;
      w1c_q <= w1c_mem[op_addr];
   end

endmodule

// File: tb/tb_pcileech_cfgspace_shadow_mf.sv
// Directed bench for pcileech_cfgspace_shadow_mf with two functions of
// sixteen dwords each and zeroed images.
module tb_pcileech_cfgspace_shadow_mf;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   pcileech_cfgspace_shadow_mf_if bus();

   pcileech_cfgspace_shadow_mf #(
      .NUM_FUNCTIONS(2), .DEPTH_DW(16),
      .INIT_FILE(""), .RW_MASK_FILE(""), .W1C_MASK_FILE("")
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic host_op(input logic we, input logic [1:0] sel, input logic [3:0] fn,
                          input logic [9:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
      bus.host_we = we; bus.host_sel = sel; bus.host_fn = fn;
      bus.host_addr = addr; bus.host_wdata = wd; bus.host_req = 1'b1;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (bus.host_ack) begin lat = i; break; end
      end
      rd = bus.host_rdata;
      bus.host_req = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic host_wr(input logic [1:0] sel, input logic [3:0] fn,
                          input logic [9:0] addr, input logic [31:0] wd);
      logic [31:0] d;
      int l;
      host_op(1'b1, sel, fn, addr, wd, d, l);
   endtask

   task automatic cfg_wr(input logic [3:0] fn, input logic [9:0] rg,
                         input logic [31:0] wd, input logic [3:0] be);
      bus.cfg_ext_function_number = fn; bus.cfg_ext_register_number = rg;
      bus.cfg_ext_write_data = wd; bus.cfg_ext_write_byte_enable = be;
      bus.cfg_ext_write_received = 1'b1;
      @(posedge clk); #1;
      bus.cfg_ext_write_received = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic cfg_rd(input logic [3:0] fn, input logic [9:0] rg,
                         output logic [31:0] d, output int lat, output logic after);
      bus.cfg_ext_function_number = fn; bus.cfg_ext_register_number = rg;
      bus.cfg_ext_read_received = 1'b1;
      @(posedge clk); #1;
      bus.cfg_ext_read_received = 1'b0;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (bus.cfg_ext_read_data_valid) begin lat = i; break; end
      end
      d = bus.cfg_ext_read_data;
      @(posedge clk); #1;
      after = bus.cfg_ext_read_data_valid;
   endtask

   initial begin
      logic [31:0] d, hr, cr;
      logic        aft;
      int          lat, c_ack, c_val, nval;

      bus.cfg_ext_read_received = 0; bus.cfg_ext_write_received = 0;
      bus.cfg_ext_register_number = 0; bus.cfg_ext_function_number = 0;
      bus.cfg_ext_write_data = 0; bus.cfg_ext_write_byte_enable = 0;
      bus.host_req = 0; bus.host_we = 0; bus.host_sel = 0;
      bus.host_fn = 0; bus.host_addr = 0; bus.host_wdata = 0;

      // reset state
      do_reset();
      chk("rst_read_data", bus.cfg_ext_read_data, 32'h0);
      chk("rst_valid", 32'(bus.cfg_ext_read_data_valid), 32'h0);
      chk("rst_ack", 32'(bus.host_ack), 32'h0);
      chk("rst_rdata", bus.host_rdata, 32'h0);
      chk("rst_err", 32'(bus.cfg_err), 32'h0);

      // image check: zero image, ack three cycles after request
      host_op(1'b0, 2'd0, 4'd0, 10'd0, 32'h0, d, lat);
      chk("img_word0", d, 32'h0);
      chk("img_lat", 32'(lat), 32'd3);

      // RW bytes
      host_wr(2'd0, 4'd0, 10'd1, 32'h0210_0000);
      host_wr(2'd1, 4'd0, 10'd1, 32'h0000_FFFF);
      host_op(1'b0, 2'd1, 4'd0, 10'd1, 32'h0, d, lat);
      chk("rw_mask_rd", d, 32'h0000_FFFF);
      cfg_wr(4'd0, 10'd1, 32'hFFFF_0547, 4'b0011);
      cfg_rd(4'd0, 10'd1, d, lat, aft);
      chk("rw_result", d, 32'h0210_0547);
      chk("rd_lat", 32'(lat), 32'd3);
      chk("rd_pulse_width", 32'(aft), 32'h0);

      // W1C with partial enables
      host_wr(2'd2, 4'd0, 10'd2, 32'hF900_0000);
      host_wr(2'd0, 4'd0, 10'd2, 32'hF900_0000);
      cfg_wr(4'd0, 10'd2, 32'h8100_0000, 4'b1000);
      cfg_rd(4'd0, 10'd2, d, lat, aft);
      chk("w1c_clear", d, 32'h7800_0000);
      host_wr(2'd0, 4'd0, 10'd2, 32'hF900_0000);
      cfg_wr(4'd0, 10'd2, 32'h8100_0000, 4'b0111);
      cfg_rd(4'd0, 10'd2, d, lat, aft);
      chk("w1c_be_off", d, 32'hF900_0000);
      chk("err_clean", 32'(bus.cfg_err), 32'h0);

      // multi-function isolation
      host_wr(2'd1, 4'd0, 10'd4, 32'hFFFF_FFFF);
      host_wr(2'd1, 4'd1, 10'd4, 32'hFFFF_FFFF);
      host_wr(2'd0, 4'd0, 10'd4, 32'h1122_3344);
      cfg_wr(4'd1, 10'd4, 32'hAABB_CCDD, 4'b1111);
      cfg_rd(4'd1, 10'd4, d, lat, aft);
      chk("fn1_write", d, 32'hAABB_CCDD);
      cfg_rd(4'd0, 10'd4, d, lat, aft);
      chk("fn0_untouched", d, 32'h1122_3344);
      host_op(1'b0, 2'd2, 4'd0, 10'd2, 32'h0, d, lat);
      chk("host_w1c_rd", d, 32'hF900_0000);
      host_op(1'b0, 2'd3, 4'd0, 10'd4, 32'h0, d, lat);
      chk("host_sel3_rd", d, 32'h0);
      host_op(1'b0, 2'd0, 4'd1, 10'd4, 32'h0, d, lat);
      chk("host_fn1_rd", d, 32'hAABB_CCDD);
      host_op(1'b0, 2'd0, 4'd0, 10'd20, 32'h0, d, lat);
      chk("host_oor_rd", d, 32'h0);
      chk("host_oor_lat", 32'(lat), 32'd3);
      chk("host_oor_noerr", 32'(bus.cfg_err), 32'h0);
      cfg_rd(4'd2, 10'd0, d, lat, aft);
      chk("fn2_rd", d, 32'h0);
      chk("fn2_lat", 32'(lat), 32'd3);
      chk("fn2_err", 32'(bus.cfg_err), 32'h1);
      do_reset();
      chk("err_after_rst", 32'(bus.cfg_err), 32'h0);
      cfg_rd(4'd0, 10'd4, d, lat, aft);
      cfg_rd(4'd0, 10'd16, d, lat, aft);
      chk("reg_oor_rd", d, 32'h0);
      chk("reg_oor_err", 32'(bus.cfg_err), 32'h1);
      do_reset();

      // collision: host first, cfg read served three cycles later
      bus.host_we = 0; bus.host_sel = 0; bus.host_fn = 0; bus.host_addr = 10'd1;
      bus.host_req = 1'b1;
      @(posedge clk); #1;
      bus.cfg_ext_function_number = 4'd1; bus.cfg_ext_register_number = 10'd4;
      bus.cfg_ext_read_received = 1'b1;
      c_ack = 0; c_val = 0; hr = 0; cr = 0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (c == 1) bus.cfg_ext_read_received = 1'b0;
         if (bus.host_ack && c_ack == 0) begin c_ack = c; hr = bus.host_rdata; bus.host_req = 1'b0; end
         if (bus.cfg_ext_read_data_valid && c_val == 0) begin c_val = c; cr = bus.cfg_ext_read_data; end
      end
      bus.host_req = 1'b0;
      chk("coll_ack_cycle", 32'(c_ack), 32'd2);
      chk("coll_val_cycle", 32'(c_val), 32'd5);
      chk("coll_host_data", hr, 32'h0210_0547);
      chk("coll_cfg_data", cr, 32'hAABB_CCDD);
      chk("coll_noerr", 32'(bus.cfg_err), 32'h0);

      // second event while slot full is dropped
      bus.host_addr = 10'd4; bus.host_req = 1'b1;
      @(posedge clk); #1;
      bus.cfg_ext_function_number = 4'd0; bus.cfg_ext_register_number = 10'd1;
      bus.cfg_ext_read_received = 1'b1;
      nval = 0; cr = 0;
      for (int c = 1; c <= 14; c++) begin
         @(posedge clk); #1;
         if (c == 1) bus.cfg_ext_register_number = 10'd2;
         if (c == 2) bus.cfg_ext_read_received = 1'b0;
         if (bus.host_ack) bus.host_req = 1'b0;
         if (bus.cfg_ext_read_data_valid) begin nval++; cr = bus.cfg_ext_read_data; end
      end
      bus.host_req = 1'b0;
      chk("drop_nvalid", 32'(nval), 32'd1);
      chk("drop_data", cr, 32'h0210_0547);
      chk("drop_err", 32'(bus.cfg_err), 32'h1);

      // simultaneous read and write: read kept, write dropped
      do_reset();
      bus.cfg_ext_function_number = 4'd0; bus.cfg_ext_register_number = 10'd1;
      bus.cfg_ext_write_data = 32'h0; bus.cfg_ext_write_byte_enable = 4'hF;
      bus.cfg_ext_read_received = 1'b1; bus.cfg_ext_write_received = 1'b1;
      @(posedge clk); #1;
      bus.cfg_ext_read_received = 1'b0; bus.cfg_ext_write_received = 1'b0;
      nval = 0; cr = 0;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (bus.cfg_ext_read_data_valid) begin nval++; cr = bus.cfg_ext_read_data; end
      end
      chk("both_nvalid", 32'(nval), 32'd1);
      chk("both_data", cr, 32'h0210_0547);
      chk("both_err", 32'(bus.cfg_err), 32'h1);
      do_reset();
      cfg_rd(4'd0, 10'd1, d, lat, aft);
      chk("both_wr_dropped", d, 32'h0210_0547);

      // reset during MOD of a cfg write
      cfg_rd(4'd3, 10'd0, d, lat, aft);
      cfg_rd(4'd0, 10'd1, d, lat, aft);
      bus.cfg_ext_function_number = 4'd0; bus.cfg_ext_register_number = 10'd4;
      bus.cfg_ext_write_data = 32'h0; bus.cfg_ext_write_byte_enable = 4'hF;
      bus.cfg_ext_write_received = 1'b1;
      @(posedge clk); #1;
      bus.cfg_ext_write_received = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_read_data", bus.cfg_ext_read_data, 32'h0);
      chk("mid_rst_valid", 32'(bus.cfg_ext_read_data_valid), 32'h0);
      chk("mid_rst_rdata", bus.host_rdata, 32'h0);
      chk("mid_rst_err", 32'(bus.cfg_err), 32'h0);
      nval = 0;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         if (bus.cfg_ext_read_data_valid || bus.host_ack) nval++;
      end
      chk("mid_rst_no_pulse", 32'(nval), 32'd0);
      cfg_rd(4'd0, 10'd4, d, lat, aft);
      chk("mid_rst_no_wb", d, 32'h1122_3344);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
